// File: rtl/ram_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_pkg (package)
//  Purpose  : Shared types and helpers for the parametrised register RAM.
//             Holds the clear-sequencer state encoding and a ceil(log2)
//             helper usable by tools that lack $clog2.
//  Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

    // Clear sequencer states; explicit 1-bit encoding.
    typedef enum logic [0:0] {
        RAM_IDLE  = 1'b0,
        RAM_CLEAR = 1'b1
    } ram_state_t;

    // Ceiling log2. Returns the number of address bits for 'value' words.
    function automatic int clog2(input int value);
        int v;
        int result;
        v      = value - 1;
        result = 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_param_if (interface)
//  Purpose  : Flat RAM access bus: write enable, address, write/read data,
//             plus bulk-clear request and busy/done status.
//  Ports    : master - drives load/addr/in/clear, observes out/busy/done
//             slave  - the RAM side
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_param_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    import ram_pkg::*;

    localparam int AW = clog2(DEPTH);

    logic             load;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             clear;
    logic             busy;
    logic             done;

    modport master (
        output load, addr, in, clear,
        input  out, busy, done
    );

    modport slave (
        input  load, addr, in, clear,
        output out, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/ram_param_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ram_clear_seq
//  Purpose  : Bulk-clear sequencer. On a clear request in IDLE it sweeps a
//             pointer over every word (one per cycle), issuing a zero write
//             to each, then returns to IDLE with a one-cycle done pulse.
//  Ports    : clk, reset (async, active-high), clear (request in),
//             busy, done (status out), clr_we/clr_addr (zero-write strobe)
//  Revision : 1.0 - initial release
// ============================================================================
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          clear,
    output logic               busy,
    output logic               done,
    output logic               clr_we,
    output logic [AW-1:0]      clr_addr
);

    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    ram_state_t      r_state;
    logic [AW-1:0]   r_ptr;
    logic            r_busy;
    logic            r_done;

    // Single FSM block; busy and done are registered alongside the state so
    // that busy rises the cycle after clear is sampled and done lands on the
    // first idle cycle. A clear arriving in CLEAR is simply not looked at.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RAM_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                RAM_IDLE: begin
                    r_done <= 1'b0;
                    if (clear) begin
                        r_state <= RAM_CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RAM_CLEAR: begin
                    // Terminal compare on DEPTH-1 keeps ptr inside the array
                    // for any depth, power of two or not.
                    if (r_ptr == c_LAST) begin
                        r_state <= RAM_IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_ptr   <= r_ptr + AW'(1);
                    end
                end
                default: begin
                    r_state <= RAM_IDLE;
                    r_ptr   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign clr_we   = r_busy;
    assign clr_addr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/ram_param.sv
`default_nettype none
// ============================================================================
//  Module   : ram_param
//  Purpose  : Parametrised WIDTH x DEPTH register RAM with combinational
//             read, single-port synchronous write and a hardware bulk clear.
//             Out-of-range addresses read 0 and ignore writes.
//  Ports    : clk, reset (async, active-high), bus (ram_param_if.slave:
//             load, addr, in, out, clear, busy, done)
//  Revision : 1.0 - initial release
// ============================================================================
module ram_param
    import ram_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    ram_param_if.slave    bus
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_busy;
    logic             w_done;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_addr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_out;

    ram_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clear    (bus.clear),
        .busy     (w_busy),
        .done     (w_done),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // The sweep owns the write port while busy, so its zero data wins.
    assign w_wdata = w_clr_we ? '0 : bus.in;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        localparam logic [AW-1:0] c_IDX = AW'(i);
        logic w_we;

        // Host writes are blocked while busy; an address >= DEPTH decodes to
        // no word at all, so it is dropped without extra logic.
        assign w_we = (w_clr_we && (w_clr_addr == c_IDX)) ||
                      (bus.load && !w_busy && (bus.addr == c_IDX));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_mem[i] <= '0;
            end else if (w_we) begin
                r_mem[i] <= w_wdata;
            end
        end
    end

    // Address-decoded read mux; unmatched (out-of-range) addresses give 0.
    always_comb begin
        w_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.addr == AW'(i)) begin
                w_out = r_mem[i];
            end
        end
    end

    assign bus.out  = w_out;
    assign bus.busy = w_busy;
    assign bus.done = w_done;

endmodule
`default_nettype wire

// File: doc/ram_param.md
Name: ram_param

Overview:
- Parametrised successor to the fixed 8x16 register RAM: WIDTH-bit words, DEPTH words, same flat load/addr/in/out interface and combinational read.
- Adds a hardware bulk-clear sequencer that zeroes the whole array in DEPTH cycles.
- Adds a busy/ready indication, a done pulse, and defined handling of out-of-range addresses for non-power-of-2 depths.
- Used as the generic memory building block for larger RAMs and the CPU data memory.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 8, number of words (>=2; need not be a power of 2).
- AW, $clog2(DEPTH), address width; derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  write enable; writes in to mem[addr] on the next rising edge when accepted.
- addr  input  AW  word address for both the read and the write.
- in  input  WIDTH  write data.
- out  output  WIDTH  combinational read data, mem[addr].
- clear  input  1  single-cycle request to start a bulk clear.
- busy  output  1  high while the clear sequence runs.
- done  output  1  one-cycle pulse after the last word is cleared.

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high. While reset=1:
  - every word = 0;
  - FSM = IDLE, clear pointer = 0;
  - busy = 0, done = 0, out = 0.
- Read:
  - out = mem[addr] combinationally; zero-cycle latency.
  - If addr >= DEPTH, out = 0.
  - Reads remain valid while busy, returning the partially cleared contents.
- Write:
  - In IDLE, load=1 with addr < DEPTH: mem[addr] <= in at the rising edge. out shows the new value after that edge; there is no same-cycle bypass.
  - load with addr >= DEPTH is silently dropped.
  - load while busy=1 is dropped, with no side effects.
- FSM states:
  - IDLE: busy=0. clear=1 moves to CLEAR with ptr=0.
  - CLEAR: busy=1. Each cycle, mem[ptr] <= 0 and ptr <= ptr+1. When ptr == DEPTH-1, that word is cleared, the FSM moves to IDLE, and done=1 for exactly the following cycle.
- Clear timing:
  - busy is asserted the cycle after clear is sampled and stays high for exactly DEPTH cycles.
  - done is registered and coincides with the first cycle of busy=0.
- Simultaneous events:
  - clear=1 and load=1 in the same IDLE cycle: the write is performed, then the sweep clears that word as well.
  - clear=1 while in CLEAR: ignored; no restart and no extension of the sweep.
  - clear=1 in the same cycle done=1: accepted; a new sweep starts.
- Reset mid-clear: the array is zeroed immediately, the FSM returns to IDLE, and done is not pulsed.
- Width rules:
  - ptr is AW bits wide and never reaches values >= DEPTH.
  - For DEPTH a power of 2, the terminal compare is on DEPTH-1 and there is no wrap.

Decomposition:
- Shared package ram_pkg holds:
  - ram_state_t enum {RAM_IDLE, RAM_CLEAR};
  - a function clog2 for tools that lack $clog2.
- Sub-module ram_clear_seq:
  - contains the FSM, ptr counter, busy and done;
  - outputs clr_we and clr_addr.
- Top level:
  - ORs the clear write into the storage array's per-word write enables (decoded load qualified by !busy);
  - the write data is 0 when clr_we=1.
- Storage is a generate-loop array of WIDTH-bit registers, with an addr-decoded read mux.

Test Plan:
- Reset: assert reset mid-cycle with no clock edge -> out=0 immediately for all addr; busy=0, done=0.
- Write/read: WIDTH=16, DEPTH=8. Write 0xA5A5 to addr 3 and 0x1234 to addr 7 -> addr=3 reads 0xA5A5, addr=7 reads 0x1234, other addresses read 0.
- Out-of-range: DEPTH=6, AW=3. Write 0xFFFF to addr 6 -> addr 6 reads 0 and addresses 0-5 are unchanged.
- Bulk clear, first part: DEPTH=8, all words filled with 0xFFFF, pulse clear ->
  - busy high for exactly 8 cycles;
  - done pulses 1 cycle on the first busy=0 cycle;
  - all words read 0.
- Bulk clear, second part: during busy, load 0xBEEF to addr 0 -> dropped, so mem[0]=0 after done.
- Collisions:
  - clear together with load 0x5555 to addr 2 -> mem[2]=0 after done.
  - a second clear during busy -> busy stays exactly 8 cycles.
  - clear on the done cycle -> a new 8-cycle sweep.
- Reset mid-clear: assert reset at sweep cycle 4 -> busy=0 immediately, all words 0, no done pulse. After reset release, a normal write to addr 1 of 0x0F0F reads back 0x0F0F.
